// File: rtl/const_pack.sv
// Shared dimensions of the interleaved ADC datapath.
package const_pack;
    localparam int unsigned Nti  = 16;
    localparam int unsigned Nadc = 8;
endpackage

// File: rtl/pfd_offset_cal_seq_pkg.sv
// Types and widths private to the offset calibration sequencer.
package pfd_offset_cal_seq_pkg;
    import const_pack::*;

    localparam int unsigned Nsettle_w = 16;
    localparam int unsigned Niter_w   = 4;
    localparam int unsigned Nslice_w  = $clog2(Nti);
    localparam int unsigned Nshift_w  = 3;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SETTLE,
        SAMPLE,
        UPDATE,
        DONE
    } cal_state_t;
endpackage

// File: rtl/pfd_offset_cal_seq_sat_sub_shift.sv
// Offset correction: off - ((avg - tgt) >>> shift), clamped to the W-bit signed range.
module sat_sub_shift #(
    parameter int unsigned W = 8
) (
    input  logic signed [W-1:0] avg_i,
    input  logic signed [W-1:0] tgt_i,
    input  logic signed [W-1:0] off_i,
    input  logic        [2:0]   shift_i,
    output logic signed [W-1:0] res_c_o,
    output logic                ovf_c_o
);
    localparam int unsigned EW = W + 1;
    localparam int unsigned NW = W + 2;

    logic signed [EW-1:0] err;
    logic signed [EW-1:0] step;
    logic signed [NW-1:0] nxt;
    logic signed [NW-1:0] max_v;
    logic signed [NW-1:0] min_v;

    assign max_v = {{(NW-W+1){1'b0}}, {(W-1){1'b1}}};
    assign min_v = {{(NW-W+1){1'b1}}, {(W-1){1'b0}}};

    // Error, arithmetic step and saturating subtract; NW bits cannot overflow.
    always_comb begin
        err     = $signed({avg_i[W-1], avg_i}) - $signed({tgt_i[W-1], tgt_i});
        step    = err >>> shift_i;
        nxt     = $signed({off_i[W-1], off_i[W-1], off_i}) - $signed({step[EW-1], step});
        res_c_o = nxt[W-1:0];
        ovf_c_o = 1'b0;
        if (nxt > max_v) begin
            res_c_o = max_v[W-1:0];
            ovf_c_o = 1'b1;
        end else if (nxt < min_v) begin
            res_c_o = min_v[W-1:0];
            ovf_c_o = 1'b1;
        end
    end
endmodule

// File: rtl/pfd_offset_cal_seq.sv
// Walks all interleaved slices, measuring each average and nudging its offset toward target.
module pfd_offset_cal_seq
    import const_pack::*, pfd_offset_cal_seq_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     abort,
    input  logic [Nsettle_w-1:0]     settle_cycles,
    input  logic [Niter_w-1:0]       n_iter,
    input  logic [Nshift_w-1:0]      gain_shift,
    input  logic signed [Nadc-1:0]   target,
    input  logic [Nti*Nadc-1:0]      adcout_avg,
    output logic [Nti*Nadc-1:0]      ext_pfd_offset,
    output logic                     en_ext_pfd_offset,
    output logic                     avg_restart,
    output logic [Nslice_w-1:0]      cur_slice,
    output logic                     busy,
    output logic                     done,
    output logic                     sat_flag
);
    cal_state_t              state_q;
    logic signed [Nadc-1:0]  offs_q [Nti];
    logic signed [Nadc-1:0]  avg_q;
    logic [Nsettle_w-1:0]    settle_q;
    logic [Nsettle_w-1:0]    settle_d;
    logic [Niter_w-1:0]      iter_q;
    logic [Nslice_w-1:0]     slice_q;
    logic                    en_q;
    logic                    restart_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    sat_q;
    logic signed [Nadc-1:0]  upd_res;
    logic                    upd_ovf;

    // A zero settle request is treated as one cycle.
    assign settle_d = (settle_cycles == '0) ? Nsettle_w'(1) : settle_cycles;

    sat_sub_shift #(.W(Nadc)) u_sat_sub_shift (
        .avg_i   (avg_q),
        .tgt_i   (target),
        .off_i   (offs_q[slice_q]),
        .shift_i (gain_shift),
        .res_c_o (upd_res),
        .ovf_c_o (upd_ovf)
    );

    // Sequencer state, counters, offset bank and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            avg_q     <= '0;
            settle_q  <= '0;
            iter_q    <= '0;
            slice_q   <= '0;
            en_q      <= 1'b0;
            restart_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sat_q     <= 1'b0;
            for (int i = 0; i < Nti; i++) begin
                offs_q[i] <= '0;
            end
        end else begin
            restart_q <= 1'b0;
            done_q    <= 1'b0;
            if (abort) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start) begin
                            sat_q   <= 1'b0;
                            slice_q <= '0;
                            iter_q  <= '0;
                            en_q    <= 1'b1;
                            busy_q  <= 1'b1;
                            if (n_iter == '0) begin
                                state_q <= DONE;
                                done_q  <= 1'b1;
                            end else begin
                                state_q   <= CLEAR;
                                restart_q <= 1'b1;
                            end
                        end
                    end
                    CLEAR: begin
                        settle_q <= settle_d;
                        state_q  <= SETTLE;
                    end
                    SETTLE: begin
                        if (settle_q <= Nsettle_w'(1)) begin
                            state_q <= SAMPLE;
                        end else begin
                            settle_q <= settle_q - Nsettle_w'(1);
                        end
                    end
                    SAMPLE: begin
                        avg_q   <= adcout_avg[slice_q*Nadc +: Nadc];
                        state_q <= UPDATE;
                    end
                    UPDATE: begin
                        offs_q[slice_q] <= upd_res;
                        if (upd_ovf) begin
                            sat_q <= 1'b1;
                        end
                        if (slice_q != Nslice_w'(Nti - 1)) begin
                            slice_q   <= slice_q + Nslice_w'(1);
                            state_q   <= CLEAR;
                            restart_q <= 1'b1;
                        end else begin
                            slice_q <= '0;
                            iter_q  <= iter_q + Niter_w'(1);
                            if ((iter_q + Niter_w'(1)) == n_iter) begin
                                state_q <= DONE;
                                done_q  <= 1'b1;
                            end else begin
                                state_q   <= CLEAR;
                                restart_q <= 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Flatten the offset bank onto the dcore bus.
    always_comb begin
        ext_pfd_offset = '0;
        for (int i = 0; i < Nti; i++) begin
            ext_pfd_offset[i*Nadc +: Nadc] = offs_q[i];
        end
    end

    assign en_ext_pfd_offset = en_q;
    assign avg_restart       = restart_q;
    assign cur_slice         = slice_q;
    assign busy              = busy_q;
    assign done              = done_q;
    assign sat_flag          = sat_q;
endmodule
